// File: rtl/tetris_pkg.sv
// Shared types and sizes for the tetron datapath: board geometry, offset vectors
// and the collision-checker state encoding.
package tetris_pkg;

   localparam int BOARD_W_DEF = 10;
   localparam int BOARD_H_DEF = 20;
   localparam int OFFS_W      = 5;
   localparam int COORD_W     = 5;
   // Widened signed sum so pivot + offset never wraps (range -16..46).
   localparam int SUM_W       = 7;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } chk_state_e;

   typedef struct packed {
      logic [OFFS_W-1:0] voff;
      logic [OFFS_W-1:0] hoff;
   } blk_offset_t;

   // Index 0 is blk1, index 3 is blk4.
   typedef blk_offset_t [3:0] offset_vec_t;

endpackage

// File: rtl/tetron_collision_checker_if.sv
// Board occupancy RAM read port used by the collision checker.
interface tetron_collision_checker_if;
   import tetris_pkg::*;

   // rd_en is a one-cycle read strobe with no backpressure; rd_occupied is valid
   // exactly one cycle after each rd_en and is meaningless at any other time.
   logic               rd_en;
   logic [COORD_W-1:0] rd_x;
   logic [COORD_W-1:0] rd_y;
   logic               rd_occupied;

   modport master (output rd_en, output rd_x, output rd_y, input rd_occupied);
   modport slave  (input rd_en, input rd_x, input rd_y, output rd_occupied);

endinterface

// File: rtl/tetron_cell_addr.sv
// Combinational absolute-cell calculator: pivot + signed offset, with bounds
// classification (out of board vs. above the top spawn zone).
module tetron_cell_addr
   import tetris_pkg::*;
#(
   parameter int BOARD_W = BOARD_W_DEF,
   parameter int BOARD_H = BOARD_H_DEF
) (
   input  logic [COORD_W-1:0] pivot_x,
   input  logic [COORD_W-1:0] pivot_y,
   input  blk_offset_t        offset,
   output logic [COORD_W-1:0] ax,
   output logic [COORD_W-1:0] ay,
   output logic               oob,
   output logic               above_top
);

   localparam logic signed [SUM_W-1:0] W_LIM = SUM_W'(BOARD_W);
   localparam logic signed [SUM_W-1:0] H_LIM = SUM_W'(BOARD_H);

   logic signed [SUM_W-1:0] sx;
   logic signed [SUM_W-1:0] sy;

   always_comb begin
      sx = $signed({{(SUM_W-COORD_W){1'b0}}, pivot_x})
         + $signed({{(SUM_W-OFFS_W){offset.hoff[OFFS_W-1]}}, offset.hoff});
      sy = $signed({{(SUM_W-COORD_W){1'b0}}, pivot_y})
         + $signed({{(SUM_W-OFFS_W){offset.voff[OFFS_W-1]}}, offset.voff});
      // Off the sides or below the floor collides; a horizontal violation wins
      // over the harmless above-the-top case.
      oob       = sx[SUM_W-1] || (sx >= W_LIM) || (!sy[SUM_W-1] && (sy >= H_LIM));
      above_top = !oob && sy[SUM_W-1];
      ax        = sx[COORD_W-1:0];
      ay        = sy[COORD_W-1:0];
   end

endmodule

// File: rtl/tetron_collision_checker.sv
// Probes the board RAM for the four cells of a candidate tetron placement and
// reports a collision. Define TETRON_COLLIDE_EARLY_ABORT_EN to stop at the first hit.
module tetron_collision_checker
   import tetris_pkg::*;
#(
   parameter int BOARD_W = BOARD_W_DEF,
   parameter int BOARD_H = BOARD_H_DEF
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic [COORD_W-1:0] pivot_x,
   input  logic [COORD_W-1:0] pivot_y,
   input  logic [OFFS_W-1:0]  blk1_voffset,
   input  logic [OFFS_W-1:0]  blk2_voffset,
   input  logic [OFFS_W-1:0]  blk3_voffset,
   input  logic [OFFS_W-1:0]  blk4_voffset,
   input  logic [OFFS_W-1:0]  blk1_hoffset,
   input  logic [OFFS_W-1:0]  blk2_hoffset,
   input  logic [OFFS_W-1:0]  blk3_hoffset,
   input  logic [OFFS_W-1:0]  blk4_hoffset,
   output logic               busy,
   output logic               done,
   output logic               collide,
   output chk_state_e         dbg_state,
   tetron_collision_checker_if.master ram
);

   chk_state_e         state;
   logic [1:0]         idx;
   logic [COORD_W-1:0] px;
   logic [COORD_W-1:0] py;
   offset_vec_t        offs;
   logic               flag;
   logic               rd_pending;

   blk_offset_t        cur_off;
   logic [COORD_W-1:0] cell_x;
   logic [COORD_W-1:0] cell_y;
   logic               cell_oob;
   logic               cell_above;
   logic               issue_rd;
   logic               occ_hit;

   assign cur_off = offs[idx];

   tetron_cell_addr #(
      .BOARD_W (BOARD_W),
      .BOARD_H (BOARD_H)
   ) u_cell_addr (
      .pivot_x   (px),
      .pivot_y   (py),
      .offset    (cur_off),
      .ax        (cell_x),
      .ay        (cell_y),
      .oob       (cell_oob),
      .above_top (cell_above)
   );

   always_comb begin
      issue_rd   = (state == ST_ISSUE) && !cell_oob && !cell_above;
      ram.rd_en  = issue_rd;
      ram.rd_x   = issue_rd ? cell_x : '0;
      ram.rd_y   = issue_rd ? cell_y : '0;
   end

   // Read data only counts in the cycle right after our own strobe.
   assign occ_hit   = rd_pending & ram.rd_occupied;
   assign dbg_state = state;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= ST_IDLE;
         idx        <= 2'd0;
         px         <= '0;
         py         <= '0;
         offs       <= '0;
         flag       <= 1'b0;
         rd_pending <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
         collide    <= 1'b0;
      end else begin
         done       <= 1'b0;
         rd_pending <= issue_rd;
         case (state)
            ST_IDLE: begin
               if (start) begin
                  px      <= pivot_x;
                  py      <= pivot_y;
                  offs    <= {blk4_voffset, blk4_hoffset, blk3_voffset, blk3_hoffset,
                              blk2_voffset, blk2_hoffset, blk1_voffset, blk1_hoffset};
                  flag    <= 1'b0;
                  idx     <= 2'd0;
                  collide <= 1'b0;
                  busy    <= 1'b1;
                  state   <= ST_ISSUE;
               end
            end
            ST_ISSUE: begin
               flag <= flag | cell_oob | occ_hit;
               idx  <= idx + 2'd1;
               if (idx == 2'd3) begin
                  state <= ST_DRAIN;
               end
`ifdef TETRON_COLLIDE_EARLY_ABORT_EN
               // Any read still in flight lands during DONE and is ignored there.
               if (cell_oob || occ_hit) begin
                  state <= ST_DONE;
               end
`endif
            end
            ST_DRAIN: begin
               flag  <= flag | occ_hit;
               state <= ST_DONE;
            end
            ST_DONE: begin
               done    <= 1'b1;
               collide <= flag;
               busy    <= 1'b0;
               state   <= ST_IDLE;
            end
            default: begin
               busy  <= 1'b0;
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_tetron_collision_checker.sv
// Bench for tetron_collision_checker: vector table plus hand sequences for
// start-while-busy and mid-check reset; reads and results go through queues.
`timescale 1ns/1ps
module tb_tetron_collision_checker;
  import tetris_pkg::*;

  typedef struct {
    logic [4:0] px;
    logic [4:0] py;
    logic [4:0] v [4];
    logic [4:0] h [4];
    bit         occ_en;
    int         occ_x;
    int         occ_y;
    bit         exp_col;
  } vec_t;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       start = 1'b0;
  logic [4:0] pivot_x = '0;
  logic [4:0] pivot_y = '0;
  logic [4:0] voff_d [4];
  logic [4:0] hoff_d [4];
  logic       busy, done, collide;
  chk_state_e dbg_state;

  tetron_collision_checker_if ram ();

  tetron_collision_checker #(.BOARD_W(10), .BOARD_H(20)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .pivot_x      (pivot_x),
    .pivot_y      (pivot_y),
    .blk1_voffset (voff_d[0]),
    .blk2_voffset (voff_d[1]),
    .blk3_voffset (voff_d[2]),
    .blk4_voffset (voff_d[3]),
    .blk1_hoffset (hoff_d[0]),
    .blk2_hoffset (hoff_d[1]),
    .blk3_hoffset (hoff_d[2]),
    .blk4_hoffset (hoff_d[3]),
    .busy         (busy),
    .done         (done),
    .collide      (collide),
    .dbg_state    (dbg_state),
    .ram          (ram)
  );

  // board RAM model: junk on rd_occupied whenever no read was issued
  logic occ_mem [0:31][0:31];
  int   cyc = 0;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    ram.rd_occupied <= ram.rd_en ? occ_mem[ram.rd_y][ram.rd_x] : 1'($urandom_range(0, 1));
  end

  // scoreboard
  logic [9:0] rd_q [$];
  logic [7:0] exp_q [$];
  logic [9:0] rd_e;
  logic [7:0] ex_e;
  int n_tests = 0;
  int n_fail = 0;
  int done_cnt = 0;
  int t_start = 0;
  bit sb_on = 1'b1;

  task automatic chk(input string nm, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic int sx5(input logic [4:0] v);
    return v[4] ? int'(v) - 32 : int'(v);
  endfunction

  function automatic vec_t mk(input int px, input int py,
                              input int v0, input int h0, input int v1, input int h1,
                              input int v2, input int h2, input int v3, input int h3,
                              input int oe, input int ox, input int oy, input int col);
    vec_t r;
    r.px = 5'(px);  r.py = 5'(py);
    r.v[0] = 5'(v0); r.h[0] = 5'(h0);
    r.v[1] = 5'(v1); r.h[1] = 5'(h1);
    r.v[2] = 5'(v2); r.h[2] = 5'(h2);
    r.v[3] = 5'(v3); r.h[3] = 5'(h3);
    r.occ_en = (oe != 0); r.occ_x = ox; r.occ_y = oy;
    r.exp_col = (col != 0);
    return r;
  endfunction

  always @(negedge clk) begin
    if (sb_on && ram.rd_en) begin
      if (rd_q.size() == 0) chk("unexpected_read", 1, 0);
      else begin
        rd_e = rd_q.pop_front();
        chk("rd_xy", int'({ram.rd_x, ram.rd_y}), int'(rd_e));
      end
    end
    if (done) begin
      done_cnt++;
      if (sb_on) begin
        if (exp_q.size() == 0) chk("unexpected_done", 1, 0);
        else begin
          ex_e = exp_q.pop_front();
          chk("collide", int'(collide), int'(ex_e[0]));
          chk("latency", cyc - t_start, int'(ex_e[7:1]));
        end
      end
    end
  end

  // driver: loads the board, predicts reads/latency, pulses start, scrambles inputs
  task automatic launch(input vec_t v);
    int ax [4];
    int ay [4];
    bit rd [4];
    bit oob [4];
    bit occ [4];
    int last;
    int lat;
    for (int r = 0; r < 32; r++)
      for (int c = 0; c < 32; c++) occ_mem[r][c] = 1'b0;
    if (v.occ_en) occ_mem[v.occ_y][v.occ_x] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      ax[i]  = int'(v.px) + sx5(v.h[i]);
      ay[i]  = int'(v.py) + sx5(v.v[i]);
      oob[i] = (ax[i] < 0) || (ax[i] >= 10) || (ay[i] >= 20);
      rd[i]  = !oob[i] && (ay[i] >= 0);
      occ[i] = rd[i] && v.occ_en && (ax[i] == v.occ_x) && (ay[i] == v.occ_y);
    end
    last = 3;
    lat  = 6;
`ifdef TETRON_COLLIDE_EARLY_ABORT_EN
    for (int i = 0; i < 4; i++) begin
      if (oob[i]) begin last = i - 1; lat = i + 2; break; end
      if (occ[i]) begin last = (i < 3) ? i + 1 : 3; lat = (i < 3) ? i + 3 : 6; break; end
    end
`endif
    pivot_x = v.px;
    pivot_y = v.py;
    for (int i = 0; i < 4; i++) begin voff_d[i] = v.v[i]; hoff_d[i] = v.h[i]; end
    if (sb_on) begin
      for (int j = 0; j <= last; j++)
        if (rd[j]) rd_q.push_back({5'(ax[j]), 5'(ay[j])});
      exp_q.push_back({7'(lat), v.exp_col});
    end
    t_start = cyc + 1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    pivot_x = 5'($urandom_range(0, 31));
    pivot_y = 5'($urandom_range(0, 31));
    for (int i = 0; i < 4; i++) begin
      voff_d[i] = 5'($urandom_range(0, 31));
      hoff_d[i] = 5'($urandom_range(0, 31));
    end
  endtask

  task automatic wait_done();
    for (int k = 0; k < 20 && exp_q.size() != 0; k++) @(negedge clk);
    if (exp_q.size() != 0) begin
      chk("done_timeout", exp_q.size(), 0);
      exp_q.delete();
    end
    @(negedge clk);
    chk("reads_outstanding", rd_q.size(), 0);
    rd_q.delete();
  endtask

  vec_t vecs [13];
  int   d0;

  initial begin
    for (int i = 0; i < 4; i++) begin voff_d[i] = '0; hoff_d[i] = '0; end
    for (int r = 0; r < 32; r++)
      for (int c = 0; c < 32; c++) occ_mem[r][c] = 1'b0;

    //           px py  v0 h0  v1 h1  v2 h2  v3 h3  oe ox oy col
    vecs[0]  = mk(4, 5,  0, 0,  0, 1,  0,-1,  1,-1,  0, 0, 0, 0);
    vecs[1]  = mk(4, 5,  0, 0,  0, 1,  0,-1,  1,-1,  1, 3, 6, 1);
    vecs[2]  = mk(0, 5,  0, 0,  0, 1,  0,-1,  1, 0,  0, 0, 0, 1);
    vecs[3]  = mk(9, 5,  0, 0,  0, 1,  0,-1,  1, 0,  0, 0, 0, 1);
    vecs[4]  = mk(4, 0,  0, 0, -1, 0,  0, 1,  0,-1,  0, 0, 0, 0);
    vecs[5]  = mk(4,19,  0, 0,  1, 0,  0, 1,  0,-1,  0, 0, 0, 1);
    vecs[6]  = mk(7,12,  0, 0,  0, 0,  0, 0,  0, 0,  1, 7,12, 1);
    vecs[7]  = mk(7,12,  0, 0,  0, 0,  0, 0,  0, 0,  0, 0, 0, 0);
    vecs[8]  = mk(4, 5,  0, 0,  0, 1,  0,-1,  1,-1,  1, 4, 5, 1);
    vecs[9]  = mk(4, 5,  0, 0,  0, 1,  0,-1,  1,-1,  1, 0, 0, 0);
    vecs[10] = mk(2, 3,  0, 0,  0, 1,  1, 0,  1, 1,  1, 3, 4, 1);
    vecs[11] = mk(9,19,  0, 0,  0,-1, -1, 0, -1,-1,  1, 9,17, 0);
    vecs[12] = mk(0, 5,  0,-1,  0, 0,  0, 1,  0, 2,  0, 0, 0, 1);

    // reset values
    repeat (3) @(negedge clk);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_collide", int'(collide), 0);
    chk("rst_rd_en", int'(ram.rd_en), 0);
    chk("rst_rd_xy", int'({ram.rd_x, ram.rd_y}), 0);
    chk("rst_state", int'(dbg_state), int'(ST_IDLE));
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 13; i++) begin
      launch(vecs[i]);
      chk("busy_after_start", int'(busy), 1);
      wait_done();
    end

    // start during ISSUE and during DONE: one done only, collide held afterwards
    d0 = done_cnt;
    launch(vecs[1]);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    chk("state_in_done", int'(dbg_state), int'(ST_DONE));
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done();
    repeat (8) @(negedge clk);
    chk("single_done", done_cnt - d0, 1);
    chk("busy_ignored_start", int'(busy), 0);
    chk("collide_held", int'(collide), 1);

    // reset in the second ISSUE cycle
    sb_on = 1'b0;
    launch(vecs[0]);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", int'(busy), 0);
    chk("mid_rst_done", int'(done), 0);
    chk("mid_rst_collide", int'(collide), 0);
    chk("mid_rst_rd_en", int'(ram.rd_en), 0);
    chk("mid_rst_rd_xy", int'({ram.rd_x, ram.rd_y}), 0);
    chk("mid_rst_state", int'(dbg_state), int'(ST_IDLE));
    d0 = done_cnt;
    repeat (8) @(negedge clk);
    chk("no_done_in_rst", done_cnt - d0, 0);
    rst_n = 1'b1;
    @(negedge clk);
    sb_on = 1'b1;
    launch(vecs[1]);
    wait_done();
    launch(vecs[7]);
    wait_done();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
